// File: rtl/axi_txn_timer_ctrl_pkg.sv
// Shared types and constants for the AXI transaction latency timer.
package axi_txn_timer_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TIME_RD = 2'd1,
    TIME_WR = 2'd2
  } state_t;

  typedef enum logic {
    DIR_RD = 1'b0,
    DIR_WR = 1'b1
  } dir_t;

  // Loading 1 on the grant edge makes the count equal t1 - t0 in the end cycle.
  localparam int unsigned CNT_LOAD_VAL = 1;

endpackage

// File: rtl/simple_counter.sv
// Free-running up-counter with synchronous load and a sticky wrap flag.
module simple_counter #(
  parameter int COUNT_SIZE = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic [COUNT_SIZE-1:0] i_load_value,
  input  logic                  i_enable,
  output logic [COUNT_SIZE-1:0] o_count,
  output logic                  o_overflow
);

  logic [COUNT_SIZE-1:0] r_count;
  logic                  r_overflow;

  // Count up when enabled; a load restarts the count and clears the wrap flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (i_load) begin
      r_count    <= i_load_value;
      r_overflow <= 1'b0;
    end else if (i_enable) begin
      r_count <= r_count + COUNT_SIZE'(1);
      if (&r_count) r_overflow <= 1'b1;
    end
  end

  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/axi_txn_timer_ctrl.sv
// Arbitrates one latency counter between the AXI read and write channels,
// captures the latency of each timed transaction and counts untimed starts.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | no measurement; waiting for a start handshake
// TIME_RD | timing a read, waiting for the last R beat
// TIME_WR | timing a write, waiting for the B handshake
module axi_txn_timer_ctrl
  import axi_txn_timer_ctrl_pkg::*;
#(
  parameter int COUNT_W = 32,
  parameter int DROP_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_enable,
  input  logic               i_clear,
  input  logic               i_ar_valid,
  input  logic               i_ar_ready,
  input  logic               i_r_valid,
  input  logic               i_r_ready,
  input  logic               i_r_last,
  input  logic               i_aw_valid,
  input  logic               i_aw_ready,
  input  logic               i_b_valid,
  input  logic               i_b_ready,
  output logic               o_busy,
  output logic               o_active_dir,
  output logic [COUNT_W-1:0] o_result,
  output logic               o_result_dir,
  output logic               o_result_ovf,
  output logic               o_result_valid,
  output logic [DROP_W-1:0]  o_drop_count
);

  state_t              r_state;
  dir_t                r_rr_ptr;
  logic                r_busy;
  dir_t                r_active_dir;
  logic [COUNT_W-1:0]  r_result;
  dir_t                r_result_dir;
  logic                r_result_ovf;
  logic                r_result_valid;
  logic [DROP_W-1:0]   r_drop_count;

  logic                w_rd_start, w_wr_start, w_rd_end, w_wr_end;
  logic                w_idle, w_timing;
  logic                w_both_start, w_grant_rd, w_grant_wr;
  logic                w_match_end, w_capture;
  dir_t                w_cap_dir;
  logic [1:0]          w_drop_inc;
  logic [DROP_W:0]     w_drop_sum;
  logic [DROP_W-1:0]   w_drop_next;
  logic [COUNT_W-1:0]  w_count;
  logic                w_overflow;
  logic [COUNT_W-1:0]  w_cap_value;

  assign w_rd_start = i_ar_valid & i_ar_ready;
  assign w_wr_start = i_aw_valid & i_aw_ready;
  assign w_rd_end   = i_r_valid & i_r_ready & i_r_last;
  assign w_wr_end   = i_b_valid & i_b_ready;

  assign w_idle   = (r_state == IDLE);
  assign w_timing = ~w_idle;

  // Simultaneous starts go to whichever direction the round-robin pointer names.
  assign w_both_start = w_idle & i_enable & w_rd_start & w_wr_start;
  assign w_grant_rd   = w_idle & i_enable & w_rd_start & (~w_wr_start | (r_rr_ptr == DIR_RD));
  assign w_grant_wr   = w_idle & i_enable & w_wr_start & (~w_rd_start | (r_rr_ptr == DIR_WR));

  assign w_match_end = ((r_state == TIME_RD) & w_rd_end) | ((r_state == TIME_WR) & w_wr_end);
  // Disable aborts even when the matching end lands in the same cycle.
  assign w_capture   = i_enable & w_match_end;
  assign w_cap_dir   = (r_state == TIME_WR) ? DIR_WR : DIR_RD;
  assign w_cap_value = w_overflow ? {COUNT_W{1'b1}} : w_count;

  // While busy every start is lost; in IDLE only the loser of a tie is.
  assign w_drop_inc  = w_timing     ? ({1'b0, w_rd_start} + {1'b0, w_wr_start}) :
                       w_both_start ? 2'd1 : 2'd0;
  assign w_drop_sum  = (DROP_W+1)'(r_drop_count) + (DROP_W+1)'(w_drop_inc);
  assign w_drop_next = w_drop_sum[DROP_W] ? {DROP_W{1'b1}} : w_drop_sum[DROP_W-1:0];

  simple_counter #(
    .COUNT_SIZE (COUNT_W)
  ) u_counter (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_grant_rd | w_grant_wr),
    .i_load_value (COUNT_W'(CNT_LOAD_VAL)),
    .i_enable     (w_timing),
    .o_count      (w_count),
    .o_overflow   (w_overflow)
  );

  // Direction FSM plus registered status, result and drop-count outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_rr_ptr       <= DIR_RD;
      r_busy         <= 1'b0;
      r_active_dir   <= DIR_RD;
      r_result       <= '0;
      r_result_dir   <= DIR_RD;
      r_result_ovf   <= 1'b0;
      r_result_valid <= 1'b0;
      r_drop_count   <= '0;
    end else begin
      r_result_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_grant_rd) begin
            r_state      <= TIME_RD;
            r_busy       <= 1'b1;
            r_active_dir <= DIR_RD;
          end else if (w_grant_wr) begin
            r_state      <= TIME_WR;
            r_busy       <= 1'b1;
            r_active_dir <= DIR_WR;
          end
          if (w_both_start) r_rr_ptr <= (r_rr_ptr == DIR_RD) ? DIR_WR : DIR_RD;
        end
        TIME_RD, TIME_WR: begin
          if (!i_enable || w_match_end) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
      if (i_clear) begin
        r_result     <= '0;
        r_result_dir <= DIR_RD;
        r_result_ovf <= 1'b0;
        r_drop_count <= '0;
      end else begin
        if (w_capture) begin
          r_result       <= w_cap_value;
          r_result_dir   <= w_cap_dir;
          r_result_ovf   <= w_overflow;
          r_result_valid <= 1'b1;
        end
        r_drop_count <= w_drop_next;
      end
    end
  end

  assign o_busy         = r_busy;
  assign o_active_dir   = r_active_dir;
  assign o_result       = r_result;
  assign o_result_dir   = r_result_dir;
  assign o_result_ovf   = r_result_ovf;
  assign o_result_valid = r_result_valid;
  assign o_drop_count   = r_drop_count;

endmodule

// File: doc/axi_txn_timer_ctrl.md
# axi_txn_timer_ctrl

Controller that shares one cycle counter between the AXI read and write channels. It detects transaction start and end handshakes, grants the counter to one direction at a time, and captures the transaction latency. It also counts transactions it could not time. It sits between the passive AXI channel taps and the register block that exposes latency results.

## Interface
Parameters:
- COUNT_W, 32, width of the timing counter and of the result.
- DROP_W, 8, width of the dropped-transaction counter.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_enable  in  1  measurement enable; low aborts any active measurement.
- i_clear  in  1  one-cycle pulse; clears the result, overflow flag and drop count.
- i_ar_valid, i_ar_ready  in  1 each  read start handshake tap.
- i_r_valid, i_r_ready, i_r_last  in  1 each  read end handshake tap.
- i_aw_valid, i_aw_ready  in  1 each  write start handshake tap.
- i_b_valid, i_b_ready  in  1 each  write end handshake tap.
- o_busy  out  1  a measurement is active.
- o_active_dir  out  1  direction being timed (0 = read, 1 = write); valid while o_busy.
- o_result  out  COUNT_W  latency of the last completed transaction, in cycles.
- o_result_dir  out  1  direction of o_result.
- o_result_ovf  out  1  the counter overflowed during that measurement.
- o_result_valid  out  1  one-cycle pulse when o_result updates.
- o_drop_count  out  DROP_W  count of start handshakes not timed; saturates at all-ones.

## Operation
- Event definitions:
  - rd_start = ar_valid & ar_ready
  - wr_start = aw_valid & aw_ready
  - rd_end = r_valid & r_ready & r_last
  - wr_end = b_valid & b_ready
- FSM states: IDLE, TIME_RD, TIME_WR.
- IDLE:
  - If i_enable and exactly one start occurs, go to TIME_RD or TIME_WR for that direction.
  - If both starts occur together, grant the direction the round-robin pointer selects. Drop the other start and toggle the pointer.
  - On any grant, load the counter with 1.
- TIME_RD / TIME_WR:
  - Counter is enabled every cycle.
  - On the matching end event: capture the result, pulse o_result_valid next cycle, and return to IDLE.
  - A non-matching end event is ignored.
- Latency: start in cycle t0 and end in cycle t1 gives o_result = t1 - t0.
- Counter overflow:
  - The overflow flag is sticky for the measurement.
  - On capture with overflow set, o_result = all-ones and o_result_ovf = 1.
- Drops:
  - Any start while busy increments o_drop_count. This includes a start in the end cycle, and starts of either direction.
  - The losing start of a simultaneous pair also increments it.
  - Two drops in one cycle add 2.
  - The count saturates at all-ones.
- i_enable low:
  - In IDLE: starts are neither timed nor counted as drops.
  - In TIME_x: abort to IDLE next edge, with no result and no pulse.
- i_clear:
  - Zeroes o_result, o_result_dir, o_result_ovf and o_drop_count.
  - Beats a capture or drop in the same cycle; a captured result is discarded and there is no pulse.
  - FSM and pointer are unaffected.
- Round-robin pointer: resets to read; toggles only on a simultaneous-start grant.

## Timing
- Reset (asynchronous): state IDLE, pointer = read, all outputs 0.
- o_busy and o_active_dir are registered and asserted the cycle after the start handshake.
- o_result, o_result_dir, o_result_ovf and o_result_valid update on the edge after the end handshake. o_result_valid is high for exactly one cycle.
- o_drop_count updates on the edge after the dropped handshake.
- Reset asserted mid-measurement returns to the reset state immediately, with no result.
- Minimum latency is 1 (end in the cycle after start). An end in the start cycle itself is not recognised.

## Structure
- Shared package holds:
  - typedef enum state_t {IDLE, TIME_RD, TIME_WR}
  - typedef enum dir_t {DIR_RD = 0, DIR_WR = 1}
  - localparam for the counter load value (1).
- One sub-module: the team's existing simple_counter, instantiated with COUNT_SIZE = COUNT_W as the shared timing counter. It provides:
  - i_load / i_load_value load
  - i_enable increment
  - a sticky o_overflow cleared on load.
- The controller drives the counter's load in IDLE on grant and its enable in TIME_x.

## Test plan
- Read single: ar handshake at cycle 10, r_last handshake at cycle 17 -> o_result = 7, o_result_dir = 0, o_result_valid pulse at cycle 18.
- Simultaneous starts from reset, twice -> first grant read, second grant write; o_drop_count = 2.
- COUNT_W = 4, write end 20 cycles after start -> o_result = 15, o_result_ovf = 1.
- Overlap: read active, aw handshakes at cycles 3 and 5, rd_end with an aw handshake in the same cycle -> o_drop_count = 3; the third write is not timed.
- i_enable drops mid read measurement -> o_busy low next cycle, no o_result_valid, o_result unchanged.
- i_clear in the same cycle as rd_end -> o_result = 0, no pulse, o_drop_count = 0, FSM in IDLE.
